// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus ACK/NACK levels, default target address.
package i2c_pkg;

  localparam logic [6:0]  DEFAULT_TARGET_ADDR = 7'h6B;
  localparam logic        SDA_ACK             = 1'b0;
  localparam logic        SDA_NACK            = 1'b1;
  localparam int unsigned BIT_CNT_W           = 3;
  localparam int unsigned BYTE_W              = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_DATA,
    ST_RX_ACK,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with registered edge and START/STOP detection.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i2c_core_clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Lines reset to the idle-bus level so leaving reset never fakes a START.
  always_ff @(posedge i2c_core_clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      sda        <= 1'b1;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start      <= 1'b0;
      stop       <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      sda        <= sda_s;
      scl_rise   <= scl_s & ~scl_hist_q;
      scl_fall   <= ~scl_s & scl_hist_q;
      start      <= scl_s & scl_hist_q & ~sda_s & sda_hist_q;
      stop       <= scl_s & scl_hist_q & sda_s & ~sda_hist_q;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target responder: address match, ACK generation, byte receive/transmit to a local byte port.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i2c_core_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       rw,
  output logic       master_nack
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .i2c_core_clk (i2c_core_clk),
    .rst          (rst),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .sda          (sda),
    .scl_rise     (scl_rise),
    .scl_fall     (scl_fall),
    .start        (start),
    .stop         (stop)
  );

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0]    shift_q, shift_d, shift_in;
  logic [BYTE_W-1:0]    rx_data_q, rx_data_d;
  logic sda_out_q, sda_out_d;
  logic rx_valid_q, rx_valid_d;
  logic busy_q, busy_d;
  logic rw_q, rw_d;
  logic master_nack_q, master_nack_d;
  logic tx_load_c;

  always_ff @(posedge i2c_core_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      sda_out_q     <= 1'b1;
      rx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      rw_q          <= 1'b0;
      master_nack_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      sda_out_q     <= sda_out_d;
      rx_valid_q    <= rx_valid_d;
      busy_q        <= busy_d;
      rw_q          <= rw_d;
      master_nack_q <= master_nack_d;
    end
  end

  // In the ACK states, sda_out_q tells whether the ACK low is already on the bus.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    sda_out_d     = sda_out_q;
    rx_valid_d    = 1'b0;
    busy_d        = busy_q;
    rw_d          = rw_q;
    master_nack_d = 1'b0;
    tx_load_c     = 1'b0;
    shift_in      = {shift_q[BYTE_W-2:0], sda};

    if (start) begin
      state_d   = ST_ADDR;
      cnt_d     = 3'd7;
      busy_d    = 1'b0;
      sda_out_d = 1'b1;
    end else if (stop) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      sda_out_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: sda_out_d = 1'b1;
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (cnt_q == '0) begin
              state_d = (shift_in[7:1] == TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (sda_out_q) begin
              sda_out_d = SDA_ACK;
              busy_d    = 1'b1;
              rw_d      = shift_q[0];
            end else if (rw_q) begin
              tx_load_c = 1'b1;
              sda_out_d = tx_data[7];
              shift_d   = {tx_data[6:0], 1'b0};
              cnt_d     = 3'd7;
              state_d   = ST_TX_DATA;
            end else begin
              sda_out_d = 1'b1;
              cnt_d     = 3'd7;
              state_d   = ST_RX_DATA;
            end
          end
        end
        ST_RX_DATA: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 3'd1;
            end else if (rx_ready) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              state_d    = ST_RX_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            if (sda_out_q) begin
              sda_out_d = SDA_ACK;
            end else begin
              sda_out_d = 1'b1;
              cnt_d     = 3'd7;
              state_d   = ST_RX_DATA;
            end
          end
        end
        ST_TX_DATA: begin
          if (scl_fall) begin
            if (cnt_q == '0) begin
              sda_out_d = 1'b1;
              state_d   = ST_TX_ACK;
            end else begin
              sda_out_d = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              cnt_d     = cnt_q - 3'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise && (sda == SDA_NACK)) begin
            master_nack_d = 1'b1;
            state_d       = ST_IGNORE;
          end else if (scl_fall) begin
            tx_load_c = 1'b1;
            sda_out_d = tx_data[7];
            shift_d   = {tx_data[6:0], 1'b0};
            cnt_d     = 3'd7;
            state_d   = ST_TX_DATA;
          end
        end
        ST_IGNORE: sda_out_d = 1'b1;
        default: begin
          state_d   = ST_IDLE;
          sda_out_d = 1'b1;
        end
      endcase
    end
  end

  assign sda_out     = sda_out_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign rw          = rw_q;
  assign master_nack = master_nack_q;
  assign tx_load     = tx_load_c;

endmodule
